sfifo_ptr_ctrl: RTL and testbench

//  Occupancy, pointer and flag controller for a synchronous single-clock FIFO.
//  - Holds no data. The wrapper owns the storage array and uses wptr/rptr to address it.
//  - Sits under every sfifo_* wrapper (e.g. metadata FIFOs with an output register).
//  - Tracks the entry count, issues read/write pointers and produces exact and

---
 rtl/sfifo_ptr_ctrl.sv | 111 +++++++++++
 tb/tb_sfifo_ptr_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sfifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sfifo_ptr_ctrl
// Brief    : Occupancy, pointer and flag controller for a single-clock FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module sfifo_ptr_ctrl #(
    parameter int DEPTH_NBITS  = 3,
    parameter int FULL_LEVEL   = (1 << DEPTH_NBITS) - 1,
    parameter int PFULL_LEVEL  = FULL_LEVEL - 2,
    parameter int PEMPTY_LEVEL = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd,
    input  logic                   wr,
    output logic                   pfull,
    output logic                   pempty,
    output logic [DEPTH_NBITS:0]   ncount,
    output logic [DEPTH_NBITS:0]   count,
    output logic                   full,
    output logic                   empty,
    output logic                   fullm1,
    output logic                   emptyp1,
    output logic                   emptyp2,
    output logic [DEPTH_NBITS-1:0] nrptr,
    output logic [DEPTH_NBITS-1:0] rptr,
    output logic [DEPTH_NBITS-1:0] wptr
);

    localparam int c_CNT_W = DEPTH_NBITS + 1;
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(FULL_LEVEL);
    localparam logic [c_CNT_W-1:0] c_FULLM1 = c_CNT_W'(FULL_LEVEL - 1);
    localparam logic [c_CNT_W-1:0] c_PFULL  = c_CNT_W'(PFULL_LEVEL);
    localparam logic [c_CNT_W-1:0] c_PEMPTY = c_CNT_W'(PEMPTY_LEVEL);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_TWO    = c_CNT_W'(2);

    logic [c_CNT_W-1:0]     r_count;
    logic [DEPTH_NBITS-1:0] r_rptr;
    logic [DEPTH_NBITS-1:0] r_wptr;
    logic                   r_full;
    logic                   r_empty;
    logic                   r_fullm1;
    logic                   r_emptyp1;
    logic                   r_emptyp2;
    logic                   r_pfull;
    logic                   r_pempty;

    logic                   w_eff_rd;
    logic                   w_eff_wr;
    logic [c_CNT_W-1:0]     w_ncount;
    logic [DEPTH_NBITS-1:0] w_nrptr;

    // A write on full is allowed only when a read frees the slot in the same cycle.
    assign w_eff_rd = rd & ~r_empty;
    assign w_eff_wr = wr & (~r_full | w_eff_rd);
    assign w_ncount = r_count + c_CNT_W'(w_eff_wr) - c_CNT_W'(w_eff_rd);
    assign w_nrptr  = r_rptr + DEPTH_NBITS'(w_eff_rd);

    // Flags decode the next count so they line up with count after the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_rptr    <= '0;
            r_wptr    <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_fullm1  <= 1'b0;
            r_emptyp1 <= 1'b1;
            r_emptyp2 <= 1'b1;
            r_pfull   <= 1'b0;
            r_pempty  <= 1'b1;
        end else begin
            r_count   <= w_ncount;
            r_rptr    <= w_nrptr;
            r_wptr    <= r_wptr + DEPTH_NBITS'(w_eff_wr);
            r_full    <= (w_ncount == c_FULL);
            r_empty   <= (w_ncount == '0);
            r_fullm1  <= (w_ncount >= c_FULLM1);
            r_emptyp1 <= (w_ncount <= c_ONE);
            r_emptyp2 <= (w_ncount <= c_TWO);
            r_pfull   <= (w_ncount >= c_PFULL);
            r_pempty  <= (w_ncount <= c_PEMPTY);
        end
    end

`ifdef SFIFO_PTR_CTRL_MSGS
    always_ff @(posedge clk) begin
        if (!rst && wr && r_full && !w_eff_rd)
            $display("sfifo_ptr_ctrl error: write while full ignored");
        if (!rst && rd && r_empty)
            $display("sfifo_ptr_ctrl error: read while empty ignored");
    end
`endif

    assign ncount  = w_ncount;
    assign nrptr   = w_nrptr;
    assign count   = r_count;
    assign rptr    = r_rptr;
    assign wptr    = r_wptr;
    assign full    = r_full;
    assign empty   = r_empty;
    assign fullm1  = r_fullm1;
    assign emptyp1 = r_emptyp1;
    assign emptyp2 = r_emptyp2;
    assign pfull   = r_pfull;
    assign pempty  = r_pempty;

endmodule
`default_nettype wire

// File: tb/tb_sfifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfifo_ptr_ctrl
// Brief    : Directed and random checks of sfifo_ptr_ctrl against an address-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfifo_ptr_ctrl;

    localparam int c_DN    = 3;
    localparam int c_SLOTS = 1 << c_DN;
    localparam int c_FULL  = c_SLOTS - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rd  = 1'b0;
    logic             wr  = 1'b0;
    logic             pfull, pempty, full, empty, fullm1, emptyp1, emptyp2;
    logic [c_DN:0]    ncount, count;
    logic [c_DN-1:0]  nrptr, rptr, wptr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of slot addresses currently holding entries.
    int q_addr[$];
    int m_wptr = 0;
    int m_rptr = 0;

    sfifo_ptr_ctrl #(.DEPTH_NBITS(c_DN)) dut (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr),
        .pfull(pfull), .pempty(pempty), .ncount(ncount), .count(count),
        .full(full), .empty(empty), .fullm1(fullm1), .emptyp1(emptyp1),
        .emptyp2(emptyp2), .nrptr(nrptr), .rptr(rptr), .wptr(wptr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        int c;
        c = q_addr.size();
        check_eq("count",   int'(count),   c);
        check_eq("full",    int'(full),    int'(c == c_FULL));
        check_eq("empty",   int'(empty),   int'(c == 0));
        check_eq("fullm1",  int'(fullm1),  int'(c >= c_FULL - 1));
        check_eq("emptyp1", int'(emptyp1), int'(c <= 1));
        check_eq("emptyp2", int'(emptyp2), int'(c <= 2));
        check_eq("pfull",   int'(pfull),   int'(c >= c_FULL - 2));
        check_eq("pempty",  int'(pempty),  int'(c <= 1));
        check_eq("wptr",    int'(wptr),    m_wptr);
        check_eq("rptr",    int'(rptr),    m_rptr);
        if (c > 0) check_eq("rptr_head", int'(rptr), q_addr[0]);
    endtask

    // One clock: drive inputs after negedge, check next-state outputs, then registered ones.
    task automatic step(input logic r_v, input logic rd_v, input logic wr_v);
        bit e_rd, e_wr;
        @(negedge clk);
        rst = r_v; rd = rd_v; wr = wr_v;
        #1;
        e_rd = rd_v && (q_addr.size() > 0);
        e_wr = wr_v && ((q_addr.size() < c_FULL) || e_rd);
        if (!r_v) begin
            check_eq("ncount", int'(ncount), q_addr.size() + int'(e_wr) - int'(e_rd));
            check_eq("nrptr",  int'(nrptr),  (m_rptr + int'(e_rd)) % c_SLOTS);
        end
        if (r_v) begin
            q_addr.delete();
            m_wptr = 0;
            m_rptr = 0;
        end else begin
            if (e_rd) begin
                void'(q_addr.pop_front());
                m_rptr = (m_rptr + 1) % c_SLOTS;
            end
            if (e_wr) begin
                q_addr.push_back(m_wptr);
                m_wptr = (m_wptr + 1) % c_SLOTS;
            end
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    initial begin
        // Reset then idle
        step(1, 0, 0);
        step(1, 0, 0);
        repeat (2) step(0, 0, 0);

        // Fill to full, push on full is dropped, then read+write while full wraps wptr
        repeat (c_FULL) step(0, 0, 1);
        check_eq("wptr_at_full", int'(wptr), 7);
        step(0, 0, 1);
        step(0, 1, 1);
        check_eq("wptr_wrapped", int'(wptr), 0);

        // Drain, then read+write on empty yields count=1
        repeat (c_FULL + 1) step(0, 1, 0);
        step(0, 1, 1);
        check_eq("count_rdwr_empty", int'(count), 1);

        // Fill 3 / drain 3 from reset
        step(1, 0, 0);
        repeat (3) step(0, 0, 1);
        repeat (3) step(0, 1, 0);
        check_eq("empty_after_drain", int'(empty), 1);

        // Reset overrides a concurrent read+write at count=4
        repeat (4) step(0, 0, 1);
        step(1, 1, 1);
        check_eq("count_after_rst", int'(count), 0);

        // Random traffic with occasional reset; bias alternates fill/drain phases
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = ((i / 200) % 2 == 0) ? 75 : 25;
            step(($urandom_range(0, 99) < 1) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) >= bias) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < bias) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
